// File: rtl/char_seq_pkg.sv
// Shared constants and FSM encodings for the character sequencer.
package char_seq_pkg;
    localparam int DEFAULT_DEPTH       = 8;
    localparam int DEFAULT_DWELL_TICKS = 30;
    localparam int CHAR_W              = 7;
    localparam int WAIT_GRACE          = 2;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_ANIM = 2'd2;
    localparam logic [1:0] DWELL     = 2'd3;
endpackage

// File: rtl/char_sequencer_dwell_timer.sv
// Counts tick pulses after start and pulses done on the tick that reaches target.
module dwell_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             tick,
    input  logic [WIDTH-1:0] target,
    output logic             done
);
    logic [WIDTH-1:0] cnt;
    logic [WIDTH:0]   next_cnt;

    assign next_cnt = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    // Combinational so the caller can act on the same edge the final tick is sampled.
    assign done = tick && !start && (next_cnt == {1'b0, target});

    always_ff @(posedge clk) begin
        if (!rst_n || start)
            cnt <= '0;
        else if (tick)
            cnt <= done ? '0 : next_cnt[WIDTH-1:0];
    end
endmodule

// File: rtl/char_sequencer.sv
// Stores a short message and plays it to the 7-segment animator one character at a time.
module char_sequencer import char_seq_pkg::*; #(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int CHAR_W      = char_seq_pkg::CHAR_W,
    parameter int DWELL_TICKS = DEFAULT_DWELL_TICKS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick60,
    input  logic                     wr_en,
    input  logic [CHAR_W-1:0]        wr_char,
    input  logic                     clear,
    input  logic                     play,
    input  logic                     anim_busy,
    output logic                     char_valid,
    output logic [CHAR_W-1:0]        char_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     playing,
    output logic [$clog2(DEPTH)-1:0] idx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(DWELL_TICKS + 1);

    logic [1:0]        state;
    logic [1:0]        grace;
    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     next_idx;
    logic              wr_ok;
    logic              dwell_done;

    assign full     = (count == CW'(DEPTH));
    assign playing  = (state != IDLE);
    assign wr_ok    = (state == IDLE) && wr_en && !full && !clear;
    assign next_idx = ({1'b0, idx} == count - CW'(1)) ? '0 : idx + AW'(1);

    // Timer is held clear outside DWELL, so ticks in ISSUE/WAIT_ANIM never count.
    dwell_timer #(.WIDTH(TW)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (state != DWELL),
        .tick   (tick60 && (state == DWELL)),
        .target (TW'(DWELL_TICKS)),
        .done   (dwell_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            idx        <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            grace      <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            state      <= IDLE;
            count      <= '0;
            idx        <= '0;
            char_valid <= 1'b0;
        end else begin
            char_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        mem[count[AW-1:0]] <= wr_char;
                        count              <= count + CW'(1);
                    end
                    if (play && count != '0) begin
                        state      <= ISSUE;
                        idx        <= '0;
                        char_valid <= 1'b1;
                        char_out   <= mem[0];
                    end
                end
                ISSUE: begin
                    state <= WAIT_ANIM;
                    grace <= '0;
                end
                WAIT_ANIM: begin
                    // The animator raises busy a little after the strobe; don't trust it yet.
                    if (grace < 2'(WAIT_GRACE))
                        grace <= grace + 2'd1;
                    else if (!anim_busy)
                        state <= DWELL;
                end
                DWELL: begin
                    if (dwell_done) begin
                        if (play) begin
                            idx        <= next_idx;
                            state      <= ISSUE;
                            char_valid <= 1'b1;
                            char_out   <= mem[next_idx];
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_char_sequencer.sv
// Directed bench for char_sequencer with a strobe scoreboard and dwell-timing monitor.
module tb_char_sequencer;
    localparam int DEPTH  = 8;
    localparam int CHAR_W = 7;
    localparam int DWELL  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick60 = 1'b0;
    logic              wr_en = 1'b0;
    logic [CHAR_W-1:0] wr_char = '0;
    logic              clear = 1'b0;
    logic              play = 1'b0;
    logic              anim_busy = 1'b0;
    logic              char_valid;
    logic [CHAR_W-1:0] char_out;
    logic [3:0]        count;
    logic              full;
    logic              playing;
    logic [2:0]        idx;

    int total = 0;
    int bad   = 0;
    logic [9:0] sb [$];

    char_sequencer #(.DEPTH(DEPTH), .CHAR_W(CHAR_W), .DWELL_TICKS(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick60     (tick60),
        .wr_en      (wr_en),
        .wr_char    (wr_char),
        .clear      (clear),
        .play       (play),
        .anim_busy  (anim_busy),
        .char_valid (char_valid),
        .char_out   (char_out),
        .count      (count),
        .full       (full),
        .playing    (playing),
        .idx        (idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame tick every 4 cycles, so some ticks always land while the animator is busy.
    int tcnt = 0;
    always @(posedge clk) begin
        #2;
        tcnt++;
        tick60 = (tcnt % 4 == 0);
    end

    // Animator model: busy for 5 cycles starting with the strobe cycle.
    int bcnt = 0;
    always @(posedge clk) begin
        #2;
        if (char_valid === 1'b1) bcnt = 5;
        else if (bcnt > 0) bcnt--;
        anim_busy = (bcnt > 0);
    end

    logic prev_valid = 1'b0, prev_busy = 1'b0, prev_playing = 1'b0, prev_cnt = 1'b0;
    int   ticks_since = 0;
    always @(negedge clk) begin
        logic       counted;
        logic [9:0] exp;
        if (char_valid === 1'b1) begin
            total++;
            assert (!prev_valid) else begin
                bad++;
                $error("FAIL double_strobe observed=1 expected=0");
            end
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_strobe observed=%0h expected=none", char_out);
            end else begin
                exp = sb.pop_front();
                chk("strobe_idx_char", {22'd0, idx, char_out}, {22'd0, exp});
            end
            if (prev_playing) begin
                chk("dwell_ticks", ticks_since, DWELL);
                chk("tick_to_strobe", {31'd0, prev_cnt}, 1);
            end
            ticks_since = 0;
        end
        // A tick counts only once busy has been low for a full cycle (FSM is in DWELL).
        counted = tick60 && !anim_busy && !prev_busy;
        if (counted) ticks_since++;
        prev_cnt     = counted;
        prev_valid   = (char_valid === 1'b1);
        prev_busy    = anim_busy;
        prev_playing = (playing === 1'b1);
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_timeout_left", sb.size(), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (playing !== 1'b0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("idle_timeout_playing", {31'd0, playing}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_idx", idx, 0);
        chk("rst_char_out", char_out, 0);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_playing", playing, 0);
        chk("rst_full", full, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_char = 7'(65 + i);
            @(posedge clk); #2;
        end
        wr_en = 1'b0;
        chk("count_abc", count, 3);
        chk("full_abc", full, 0);

        sb.push_back({3'd0, 7'h41});
        sb.push_back({3'd1, 7'h42});
        sb.push_back({3'd2, 7'h43});
        sb.push_back({3'd0, 7'h41});
        play = 1'b1;
        @(negedge clk);
        chk("no_strobe_before_edge", char_valid, 0);
        @(negedge clk);
        chk("play_latency", char_valid, 1);
        @(posedge clk); #2;
        wr_en = 1'b1;
        wr_char = 7'h55;
        repeat (2) begin @(posedge clk); #2; end
        wr_en = 1'b0;
        chk("count_write_during_play", count, 3);
        wait_drain(400);

        // Drop play while in WAIT_ANIM of the wrapped 'A'.
        @(posedge clk); #2;
        play = 1'b0;
        wait_idle(200);
        chk("stop_idx", idx, 0);
        chk("stop_count", count, 3);
        repeat (20) @(posedge clk);

        sb.push_back({3'd0, 7'h41});
        play = 1'b1;
        wait_drain(50);
        repeat (7) @(posedge clk);
        #2;
        clear = 1'b1;
        wr_en = 1'b1;
        wr_char = 7'h77;
        @(posedge clk); #2;
        clear = 1'b0;
        wr_en = 1'b0;
        chk("clear_count", count, 0);
        chk("clear_idx", idx, 0);
        chk("clear_playing", playing, 0);
        chk("clear_char_valid", char_valid, 0);
        chk("clear_char_out_kept", char_out, 7'h41);
        repeat (20) @(posedge clk);
        #2;
        chk("empty_play_idle", playing, 0);
        chk("empty_play_count", count, 0);
        play = 1'b0;

        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1;
            wr_char = 7'(48 + i);
            @(posedge clk); #2;
            if (i == 6) chk("full_after7", full, 0);
            if (i == 7) chk("full_after8", full, 1);
        end
        wr_en = 1'b0;
        chk("count_after9", count, 8);
        chk("full_after9", full, 1);

        for (int i = 0; i < 8; i++) sb.push_back({3'(i), 7'(48 + i)});
        play = 1'b1;
        wait_drain(600);
        play = 1'b0;
        wait_idle(200);
        chk("full_stop_idx", idx, 7);
        chk("full_stop_count", count, 8);

        sb.push_back({3'd0, 7'h30});
        play = 1'b1;
        wait_drain(50);
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("midrst_char_valid", char_valid, 0);
        chk("midrst_char_out", char_out, 0);
        chk("midrst_count", count, 0);
        chk("midrst_idx", idx, 0);
        chk("midrst_playing", playing, 0);
        chk("midrst_full", full, 0);
        play = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/char_sequencer.md
Name: char_sequencer

Overview:
Sequencer that feeds the 7-segment animator. It stores a short message of 7-bit character codes and plays them out in a loop, one character at a time. Each character is issued to the animator as a single-cycle valid strobe, and the block then waits for the animator to finish. It then holds the character for a programmable number of 60 Hz frame ticks before advancing. It sits between the top-level input pins and the animator, replacing direct pin-to-animator character feeding.

Parameters:
DEPTH, 8, message buffer depth in characters (power of two, ≥2)
CHAR_W, 7, character code width
DWELL_TICKS, 30, tick60 pulses to hold each character after the animator goes idle (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tick60  in  1  single-cycle frame strobe from the clock divider
wr_en  in  1  write one character into the buffer
wr_char  in  CHAR_W  character to write
clear  in  1  empty the buffer and abort playback
play  in  1  level; high = play message in a loop
anim_busy  in  1  animator is animating; high while busy
char_valid  out  1  single-cycle strobe to the animator
char_out  out  CHAR_W  character for the animator; registered; holds its value between strobes
count  out  $clog2(DEPTH)+1  number of stored characters
full  out  1  count == DEPTH
playing  out  1  FSM not in IDLE
idx  out  $clog2(DEPTH)  buffer index of the current or last issued character

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; count, idx, char_out, char_valid, playing all 0; buffer entries 0.
- States: IDLE, ISSUE, WAIT_ANIM, DWELL.
- Writes:
  - Accepted only in IDLE with !full and !clear; stored at buf[count], count+1 on the next cycle.
  - Writes while full or while not in IDLE are silently dropped.
- clear, any state, highest priority: next cycle state IDLE, count 0, idx 0, char_valid 0; char_out keeps its value. clear and wr_en together: clear wins, write dropped.
- IDLE → ISSUE when play=1 and count>0. idx loads 0.
  - Latency: play sampled high at edge N gives char_valid=1 in cycle N+1.
  - play=1 with count=0: stay in IDLE.
- ISSUE, one cycle:
  - char_valid=1 and char_out=buf[idx], both registered so they are valid together.
  - Next state WAIT_ANIM. char_valid is never high for two consecutive cycles.
- WAIT_ANIM:
  - Ignores anim_busy in its first two cycles, to cover the animator's busy-assert latency.
  - From the third cycle on, anim_busy=0 → DWELL with the tick counter cleared.
- DWELL:
  - Counts tick60 pulses.
  - When the DWELL_TICKS-th pulse is sampled: if play=1, idx ← (idx==count-1) ? 0 : idx+1 and go to ISSUE. If play=0, go to IDLE with idx unchanged.
- play deasserting during ISSUE, WAIT_ANIM or DWELL does not abort; the current character completes its dwell, then the block returns to IDLE.
- Single-character message: re-issued every dwell period while play=1.
- tick60 during ISSUE or WAIT_ANIM is ignored (not counted).
- Reset mid-playback: identical to the reset values above, and the buffer is cleared.

Decomposition:
- Shared package char_seq_pkg:
  - state enum (IDLE, ISSUE, WAIT_ANIM, DWELL)
  - DEFAULT_DEPTH, DEFAULT_DWELL_TICKS, CHAR_W constants
  - WAIT_GRACE = 2
- Sub-module dwell_timer:
  - inputs clk, rst_n, start (clear), tick, target
  - output done, a one-cycle pulse when the count reaches the target
  - counter width $clog2(DWELL_TICKS+1)

Test Plan:
- Reset, then write 'A'(0x41), 'B'(0x42), 'C'(0x43); play=1 → char_valid in the cycle after play. char_out sequence 0x41, 0x42, 0x43, 0x41 (wrap); count=3 and idx returns to 0 after 2.
- DWELL_TICKS=3; anim_busy high 5 cycles after each strobe → next strobe only after anim_busy falls and exactly 3 tick60 pulses have been counted. Ticks during busy are not counted.
- Write 9 characters with DEPTH=8 → full=1 after the 8th; 9th dropped, count=8. Writes during play are dropped and count is unchanged.
- play drops during WAIT_ANIM → current character finishes its dwell, then IDLE, playing=0, no further char_valid. Re-asserting play restarts at idx=0 with 0x41.
- clear asserted together with wr_en mid-DWELL → next cycle IDLE, count=0, char_valid stays 0, char_out retains its last value.
- play=1 with count=0 → stays in IDLE, no strobe. rst_n low mid-ISSUE → all outputs 0 on the next cycle.
